// File: rtl/cacheline_adapter.sv
// Bridges one 256-bit cache line request to a 4-beat 64-bit bmem burst, one transaction at a time.
// Optional read-beat address check: define CACHELINE_ADAPTER_RADDR_CHECK_EN.
module cacheline_adapter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              raddr_err
);

  localparam int unsigned Beats = LINE_W / BEAT_W;
  localparam int unsigned CntW = $clog2(Beats);
  localparam int unsigned OffW = $clog2(LINE_W / 8);
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  typedef enum logic [2:0] {StIdle, StWr, StRdReq, StRdData, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_inc;
  logic [31-OffW:0]  tag_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] rline_q;
  logic              beat_ok;
  logic              unused_bits;

  assign cnt_inc   = cnt_q + CntW'(1);
  assign bmem_addr = {tag_q, {OffW{1'b0}}};

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  assign beat_ok     = bmem_rvalid && (bmem_raddr[31:OffW] == tag_q);
  assign unused_bits = ^{dfp_addr[OffW-1:0], bmem_raddr[OffW-1:0]};

  // Sticky until reset so a single stray beat is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_err <= 1'b0;
    end else if (state_q == StRdData && bmem_rvalid && !beat_ok) begin
      raddr_err <= 1'b1;
    end
  end
`else
  assign beat_ok     = bmem_rvalid;
  assign raddr_err   = 1'b0;
  assign unused_bits = ^{dfp_addr[OffW-1:0], bmem_raddr};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tag_q      <= '0;
      wline_q    <= '0;
      rline_q    <= '0;
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dfp_write) begin
            tag_q      <= dfp_addr[31:OffW];
            wline_q    <= dfp_wdata;
            cnt_q      <= '0;
            bmem_write <= 1'b1;
            bmem_wdata <= dfp_wdata[BEAT_W-1:0];
            state_q    <= StWr;
          end else if (dfp_read) begin
            tag_q     <= dfp_addr[31:OffW];
            bmem_read <= 1'b1;
            state_q   <= StRdReq;
          end
        end
        StWr: begin
          // Without bmem_ready the current beat and data simply hold.
          if (bmem_ready) begin
            cnt_q <= cnt_inc;
            if (cnt_q == LastBeat) begin
              bmem_write <= 1'b0;
              bmem_wdata <= '0;
              dfp_resp   <= 1'b1;
              state_q    <= StResp;
            end else begin
              bmem_wdata <= wline_q[cnt_inc*BEAT_W +: BEAT_W];
            end
          end
        end
        StRdReq: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (beat_ok) begin
            rline_q[cnt_q*BEAT_W +: BEAT_W] <= bmem_rdata;
            cnt_q <= cnt_inc;
            if (cnt_q == LastBeat) begin
              // Last beat fills the top slice; publish the whole line with it.
              dfp_rdata <= {bmem_rdata, rline_q[LINE_W-BEAT_W-1:0]};
              dfp_resp  <= 1'b1;
              state_q   <= StResp;
            end
          end
        end
        StResp: begin
          dfp_resp <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: transaction-level model checked every cycle plus literal pins.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         raddr_err;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .raddr_err(raddr_err)
  );

  always #5 clk = ~clk;

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the current transaction must look like.
  int           exp_kind;  // 0 none, 1 write, 2 read
  logic [31:0]  exp_addr;
  logic [255:0] exp_wline, asm_line, model_rdata;
  logic         model_err;
  int           beat_idx, got, reads_issued, resp_cnt;
  bit           req_acc;
  logic [31:0]  last_wr_addr, last_rd_addr;
  logic [63:0]  last_wdata;

  logic [63:0]  rdy_mask, rv_mask;
  logic [63:0]  rv_dat [64];
  logic [31:0]  rv_adr [64];
  int           lat;

  task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_cycle();
    if (rst) return;
    if (dfp_resp) resp_cnt++;
    if (dfp_resp && exp_kind == 2) model_rdata = asm_line;
    cmp("raddr_err", raddr_err, model_err);
    cmp("rd_wr_overlap", bmem_write & bmem_read, 0);
    cmp("unexpected_resp", dfp_resp && exp_kind == 0, 0);
    cmp("dfp_rdata", dfp_rdata, model_rdata);
    if (bmem_write) begin
      last_wr_addr = bmem_addr;
      last_wdata   = bmem_wdata;
      cmp("wr_in_write_txn", exp_kind == 1, 1);
      cmp("wr_addr", bmem_addr, exp_addr);
      cmp("wr_beat", bmem_wdata, exp_wline[beat_idx*64 +: 64]);
    end
    if (bmem_read) begin
      last_rd_addr = bmem_addr;
      cmp("rd_in_read_txn", exp_kind == 2, 1);
      cmp("rd_addr", bmem_addr, exp_addr);
    end
    if (dfp_resp && exp_kind == 1) cmp("wr_beats_at_resp", beat_idx, 4);
    if (dfp_resp && exp_kind == 2) cmp("rd_beats_at_resp", got, 4);
  endtask

  // Inputs apply at the coming edge; outputs visible now are what that edge consumes.
  task automatic step(input logic rdy, input logic rv, input logic [63:0] rd,
                      input logic [31:0] ra);
    bmem_ready  = rdy;
    bmem_rvalid = rv;
    bmem_rdata  = rd;
    bmem_raddr  = ra;
    if (!rst) begin
      if (bmem_write && rdy) beat_idx++;
      if (exp_kind == 2 && req_acc && rv && got < 4) begin
        if (!ChkEn || ra[31:5] == exp_addr[31:5]) begin
          asm_line[got*64 +: 64] = rd;
          got++;
        end else begin
          model_err = 1'b1;
        end
      end
      if (bmem_read && rdy) begin
        reads_issued++;
        req_acc = 1'b1;
      end
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [255:0] wline, input int rst_at, output int latency);
    dfp_addr  = addr;
    dfp_write = wr;
    dfp_read  = rd;
    dfp_wdata = wline;
    exp_kind  = wr ? 1 : (rd ? 2 : 0);
    exp_addr  = {addr[31:5], 5'b0};
    exp_wline = wline;
    asm_line  = '0;
    beat_idx = 0; got = 0; reads_issued = 0; resp_cnt = 0; req_acc = 1'b0;
    latency = 0;
    for (int n = 1; n <= 40 && latency == 0; n++) begin
      if (n == 3) dfp_addr = addr ^ 32'h00FF_FF00;
      if (n == rst_at) begin
        rst = 1'b1;
        dfp_write = 1'b0;
        dfp_read  = 1'b0;
      end
      step(rdy_mask[n], rv_mask[n], rv_dat[n], rv_adr[n]);
      if (n == rst_at) begin
        cmp("rst_ctrl_outputs",
            {dfp_resp, bmem_read, bmem_write, bmem_wdata, bmem_addr, raddr_err}, 0);
        cmp("rst_rdata", dfp_rdata, 0);
        exp_kind = 0; model_rdata = '0; model_err = 1'b0; beat_idx = 0;
        rst = 1'b0;
        return;
      end
      if (dfp_resp) latency = n + 1;
    end
    step(1'b1, 1'b0, 64'h0, 32'h0);
    dfp_write = 1'b0;
    dfp_read  = 1'b0;
    step(1'b1, 1'b0, 64'h0, 32'h0);
    step(1'b1, 1'b0, 64'h0, 32'h0);
    exp_kind = 0;
  endtask

  task automatic clear_stim();
    rdy_mask = '1;
    rv_mask  = '0;
    for (int i = 0; i < 64; i++) begin
      rv_dat[i] = '0;
      rv_adr[i] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    exp_kind = 0; model_rdata = '0; model_err = 1'b0;
    last_wr_addr = '0; last_rd_addr = '0; last_wdata = '0;
    clear_stim();
    @(negedge clk);
    @(negedge clk);
    cmp("reset_ctrl", {dfp_resp, bmem_read, bmem_write, bmem_wdata, bmem_addr, raddr_err}, 0);
    cmp("reset_rdata", dfp_rdata, 0);
    rst = 1'b0;
    step(1'b1, 1'b0, 64'h0, 32'h0);

    // Full-speed write; addr offset bits dropped.
    clear_stim();
    run_txn(1'b1, 1'b0, 32'h0000_1234, {64'hD, 64'hC, 64'hB, 64'hA}, 0, lat);
    cmp("t1_latency", lat, 6);
    cmp("t1_beats", beat_idx, 4);
    cmp("t1_resp_count", resp_cnt, 1);
    cmp("t1_bmem_addr", last_wr_addr, 32'h0000_1220);
    cmp("t1_last_beat", last_wdata, 64'hD);

    // Two stall cycles while beat 2 is presented.
    clear_stim();
    rdy_mask[4] = 1'b0;
    rdy_mask[5] = 1'b0;
    run_txn(1'b1, 1'b0, 32'h0000_2468,
            {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
             64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001}, 0, lat);
    cmp("t2_latency", lat, 8);
    cmp("t2_beats", beat_idx, 4);
    cmp("t2_resp_count", resp_cnt, 1);

    // Read with a gap; a beat during the request phase must be ignored.
    clear_stim();
    rv_mask[2] = 1'b1; rv_dat[2] = 64'hBAD; rv_adr[2] = 32'h40;
    rv_mask[5] = 1'b1; rv_dat[5] = 64'h1;   rv_adr[5] = 32'h40;
    rv_mask[6] = 1'b1; rv_dat[6] = 64'h2;   rv_adr[6] = 32'h40;
    rv_mask[8] = 1'b1; rv_dat[8] = 64'h3;   rv_adr[8] = 32'h40;
    rv_mask[9] = 1'b1; rv_dat[9] = 64'h4;   rv_adr[9] = 32'h40;
    run_txn(1'b0, 1'b1, 32'h0000_0040, '0, 0, lat);
    cmp("t3_latency", lat, 10);
    cmp("t3_reads_issued", reads_issued, 1);
    cmp("t3_resp_count", resp_cnt, 1);
    cmp("t3_rd_addr", last_rd_addr, 32'h0000_0040);
    cmp("t3_rdata_held", dfp_rdata, {64'h4, 64'h3, 64'h2, 64'h1});

    // Both requests: write wins, no read burst.
    clear_stim();
    run_txn(1'b1, 1'b1, 32'h0000_8000, {64'h8, 64'h7, 64'h6, 64'h5}, 0, lat);
    cmp("t4_latency", lat, 6);
    cmp("t4_reads_issued", reads_issued, 0);
    cmp("t4_rdata_kept", dfp_rdata, {64'h4, 64'h3, 64'h2, 64'h1});

    // Reset after the first write beat, stray beats in idle, then a clean read.
    clear_stim();
    run_txn(1'b1, 1'b0, 32'h0000_2000, {64'hEE, 64'hDD, 64'hCC, 64'hBB}, 3, lat);
    cmp("t5_beats_before_rst", lat, 0);
    step(1'b1, 1'b1, 64'hDEAD, 32'h0000_3000);
    step(1'b1, 1'b1, 64'hBEEF, 32'h0000_3000);
    step(1'b1, 1'b0, 64'h0, 32'h0);
    clear_stim();
    for (int i = 4; i <= 7; i++) begin
      rv_mask[i] = 1'b1;
      rv_dat[i]  = 64'h50 + 64'(i);
      rv_adr[i]  = 32'h0000_3000;
    end
    run_txn(1'b0, 1'b1, 32'h0000_3010, '0, 0, lat);
    cmp("t5_read_latency", lat, 8);
    cmp("t5_rdata", dfp_rdata, {64'h57, 64'h56, 64'h55, 64'h54});

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    // A beat tagged for another line is dropped and flagged.
    clear_stim();
    rv_mask[3] = 1'b1; rv_dat[3] = 64'h11; rv_adr[3] = 32'h0000_5000;
    rv_mask[4] = 1'b1; rv_dat[4] = 64'hFF; rv_adr[4] = 32'h0000_9000;
    rv_mask[5] = 1'b1; rv_dat[5] = 64'h22; rv_adr[5] = 32'h0000_5000;
    rv_mask[6] = 1'b1; rv_dat[6] = 64'h33; rv_adr[6] = 32'h0000_5000;
    rv_mask[7] = 1'b1; rv_dat[7] = 64'h44; rv_adr[7] = 32'h0000_5000;
    run_txn(1'b0, 1'b1, 32'h0000_5000, '0, 0, lat);
    cmp("t6_latency", lat, 8);
    cmp("t6_err_sticky", raddr_err, 1);
    cmp("t6_rdata", dfp_rdata, {64'h44, 64'h33, 64'h22, 64'h11});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Memory-side responder for the data cache's 256-bit line port: accepts one line read or line write from the cache and answers with a single-cycle dfp_resp.
- Converts each request into a 4-beat, 64-bit burst on the banked-memory (bmem) interface.
- Sits between the dcache/icache arbiter and main memory.
- Only one transaction is in flight at a time.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory beat width in bits; beats per line is LINE_W/BEAT_W = 4.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- dfp_addr  input  32  line address from cache; bits [4:0] ignored
- dfp_read  input  1  line read request, held until dfp_resp
- dfp_write  input  1  line write request, held until dfp_resp
- dfp_wdata  input  256  write line, stable while dfp_write is high
- dfp_rdata  output  256  read line
- dfp_resp  output  1  one-cycle completion pulse
- bmem_addr  output  32  burst address, {dfp_addr[31:5],5'b0}
- bmem_read  output  1  read burst request, one cycle
- bmem_write  output  1  write beat valid
- bmem_wdata  output  64  write beat data
- bmem_ready  input  1  memory can accept a request or beat this cycle
- bmem_raddr  input  32  address tag of the returning read beat
- bmem_rdata  input  64  read beat data
- bmem_rvalid  input  1  read beat valid
- raddr_err  output  1  sticky mismatch flag (Optional Feature)

Behaviour:
- Reset values: all outputs 0, dfp_rdata = 0, state IDLE, beat counter 0. A reset mid-burst abandons the burst; read beats arriving after reset in IDLE are ignored.

State IDLE:
- dfp_write high → latch address and wdata, go to WR.
- Else dfp_read high → latch address, go to RD_REQ.
- Write has priority if both are asserted; asserting both is illegal but must still be deterministic.

State WR:
- bmem_write = 1, bmem_wdata = line[64*cnt+63 : 64*cnt], bmem_addr = latched address.
- A beat is accepted when bmem_ready = 1; cnt then increments.
- If bmem_ready = 0, hold the current beat and data unchanged (stall).
- After beat 3 is accepted, go to RESP; bmem_write drops the next cycle.
- Best case: 4 consecutive cycles of bmem_write.

State RD_REQ:
- bmem_read = 1 and bmem_addr valid while waiting. Once bmem_ready = 1 in that cycle, go to RD_DATA.
- bmem_read is high for exactly one accepted cycle.

State RD_DATA:
- Each bmem_rvalid beat is written to line slice cnt, then cnt increments.
- Beats arrive in order 0..3 and may be non-consecutive.
- After beat 3, go to RESP.

State RESP:
- dfp_resp = 1 for exactly one cycle.
- For reads, dfp_rdata holds the assembled line in this cycle, and the register keeps that value until the next read completes.
- Next state is IDLE. A request still high in the RESP cycle is not re-accepted; the cache drops the request the cycle after dfp_resp.

Latency:
- Write: dfp_write → dfp_resp = 1 (IDLE latch) + 4 beats + 1 = 6 cycles minimum.
- Read: 1 + 1 (request) + memory latency + 4 beats + 1.

Counter rules:
- cnt is 2 bits and wraps 3→0 on the last beat.
- cnt clears on entry to WR and RD_DATA.

Boundary conditions:
- bmem_rvalid outside RD_DATA is ignored.
- dfp_addr changes mid-transaction have no effect; the address is latched.

Optional Feature:
Macro CACHELINE_ADAPTER_RADDR_CHECK_EN.
- Defined: in RD_DATA, a beat is accepted only if bmem_raddr[31:5] equals the latched address[31:5]. A mismatched beat is dropped without incrementing cnt and sets raddr_err, which stays set until rst.
- Undefined: bmem_raddr is ignored and raddr_err is tied to 0.

Test Plan:
1. Write, bmem_ready = 1 always, dfp_addr = 0x0000_1234, wdata = {64'hD,64'hC,64'hB,64'hA} → bmem_addr = 0x0000_1220 and bmem_write high 4 cycles with beats A,B,C,D; dfp_resp pulses once on cycle 6.
2. Write with bmem_ready low for 2 cycles during beat 2 → beat 2 is held unchanged through the stall, still exactly 4 beats are accepted, and dfp_resp is delayed by 2 cycles.
3. Read of 0x0000_0040 with rvalid beats 1,2,3,4 arriving in cycles 5,6,8,9 (one-cycle gap) → dfp_rdata = {64'h4,64'h3,64'h2,64'h1} during the dfp_resp cycle and held afterward; bmem_read is asserted exactly once.
4. dfp_read and dfp_write both high in IDLE → a write burst occurs; no bmem_read is issued before the write's dfp_resp.
5. rst asserted after write beat 1 → all outputs are 0 the next cycle, and a subsequent read completes normally.
6. With the macro defined, a read beat with mismatched bmem_raddr → the beat is not stored, raddr_err = 1, and the line completes from the 4 matching beats.
